// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serializer arbiter block.
// Optional burst mode is selected with SER_ARB_BURST_EN.
package ser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIT0 = 2'd1,
        BIT1 = 2'd2
    } state_e;

    localparam int SYM_W = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_arbiter_if.sv
// Requester/serializer-side bundle of the serializer arbiter.
// master = requester side driving req/sym, slave = the arbiter.
interface serializer_arbiter_if
    import ser_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [SYM_W*NUM_REQ-1:0] sym;
    logic [NUM_REQ-1:0]       ack;
    logic                     ser_valid;
    logic                     ser_v1;
    logic                     ser_v2;
    logic [IW-1:0]            ser_src;
    logic                     busy;

    modport master (
        output req, sym,
        input  ack, ser_valid, ser_v1, ser_v2, ser_src, busy
    );

    modport slave (
        input  req, sym,
        output ack, ser_valid, ser_v1, ser_v2, ser_src, busy
    );

endinterface

// File: rtl/serializer_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req at or after ptr+1, wrapping.
// Zero latency; no backpressure of its own.
module rr_picker
    import ser_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               found_o,
    output logic [IW-1:0]      winner_o
);

    int idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin scheduler feeding one 2-bit-symbol serializer; each symbol drives valid for 2 cycles.
// Grant visible 1 cycle after req sampled; back-to-back symbols; optional SER_ARB_BURST_EN owner hold.
module serializer_arbiter
    import ser_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    serializer_arbiter_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
        $error("serializer_arbiter: NUM_REQ or MAX_BURST out of range");
    end

    state_e             state_q;
    logic [IW-1:0]      ptr_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               ser_valid_q;
    logic               ser_v1_q;
    logic               ser_v2_q;
    logic [IW-1:0]      src_q;

    logic               rr_found;
    logic [IW-1:0]      rr_idx;
    logic               keep_d;
    logic               grant_d;
    logic [IW-1:0]      grant_idx_d;
    logic [SYM_W-1:0]   sym_d;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .found_o (rr_found),
        .winner_o(rr_idx)
    );

`ifdef SER_ARB_BURST_EN
    logic [3:0] burst_cnt_q;
    assign keep_d = (state_q == BIT1) && bus.req[src_q]
                    && (burst_cnt_q < 4'(MAX_BURST - 1));
`else
    assign keep_d = 1'b0;
`endif

    // req is deliberately ignored in BIT0: the requester may still be swapping symbols.
    always_comb begin
        grant_d     = (state_q != BIT0) && (keep_d || rr_found);
        grant_idx_d = keep_d ? src_q : rr_idx;
        sym_d       = bus.sym[SYM_W*grant_idx_d +: SYM_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            ack_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_v1_q    <= 1'b0;
            ser_v2_q    <= 1'b0;
            src_q       <= '0;
`ifdef SER_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE, BIT1: begin
                    if (grant_d) begin
                        state_q              <= BIT0;
                        ser_valid_q          <= 1'b1;
                        ser_v1_q             <= sym_d[1];
                        ser_v2_q             <= sym_d[0];
                        src_q                <= grant_idx_d;
                        ack_q[grant_idx_d]   <= 1'b1;
                        if (!keep_d) begin
                            ptr_q <= grant_idx_d;
                        end
`ifdef SER_ARB_BURST_EN
                        burst_cnt_q <= keep_d ? burst_cnt_q + 4'd1 : 4'd0;
`endif
                    end else begin
                        state_q     <= IDLE;
                        ser_valid_q <= 1'b0;
`ifdef SER_ARB_BURST_EN
                        burst_cnt_q <= '0;
`endif
                    end
                end
                BIT0: begin
                    state_q <= BIT1;
                end
                default: begin
                    state_q     <= IDLE;
                    ser_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_v1    = ser_v1_q;
    assign bus.ser_v2    = ser_v2_q;
    assign bus.ser_src   = src_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter with a small serializer model on the output.
// Expected grant sequences follow SER_ARB_BURST_EN when it is defined.
module tb_serializer_arbiter;

`ifdef SER_ARB_BURST_EN
    localparam int MB = 3;
`else
    localparam int MB = 4;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serializer_arbiter_if #(.NUM_REQ(4)) bus ();

    serializer_arbiter #(.NUM_REQ(4), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Serializer model: v1 on the first valid cycle, v2 on the second.
    logic ser_idx = 1'b0;
    logic out_bit = 1'b0;
    always @(posedge clk) begin
        if (reset || !bus.ser_valid) begin
            ser_idx <= 1'b0;
        end else begin
            out_bit <= ser_idx ? bus.ser_v2 : bus.ser_v1;
            ser_idx <= ~ser_idx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has already driven req; serves n symbols, dropping req after the last ack.
    task automatic run_seq(input string tag, input int seq[8], input int n);
        int g;
        step();
        for (int i = 0; i < n; i++) begin
            g = seq[i];
            check({tag, "_ack"}, bus.ack, 32'(1 << g));
            check({tag, "_src"}, bus.ser_src, g);
            check({tag, "_sym"}, {bus.ser_v1, bus.ser_v2}, g & 3);
            check({tag, "_vld0"}, bus.ser_valid, 1);
            step();
            check({tag, "_ack_bit0"}, bus.ack, 0);
            check({tag, "_vld1"}, bus.ser_valid, 1);
            check({tag, "_out_v1"}, out_bit, (g >> 1) & 1);
            if (i == n - 1) bus.req = '0;
            step();
            check({tag, "_out_v2"}, out_bit, g & 1);
        end
        check({tag, "_end_vld"}, bus.ser_valid, 0);
        check({tag, "_end_busy"}, bus.busy, 0);
    endtask

    int seq_a[8];

    initial begin
        bus.req = '0;
        bus.sym = 8'b11_10_01_00;

        // Reset state
        step();
        step();
        check("rst_ack", bus.ack, 0);
        check("rst_vld", bus.ser_valid, 0);
        check("rst_v1", bus.ser_v1, 0);
        check("rst_v2", bus.ser_v2, 0);
        check("rst_src", bus.ser_src, 0);
        check("rst_busy", bus.busy, 0);

        // Single symbol from requester 0, sym0 = 2'b10
        reset   = 1'b0;
        bus.sym = 8'b11_10_01_10;
        bus.req = 4'b0001;
        step();
        check("one_ack", bus.ack, 4'b0001);
        check("one_vld", bus.ser_valid, 1);
        check("one_sym", {bus.ser_v1, bus.ser_v2}, 2'b10);
        check("one_src", bus.ser_src, 0);
        check("one_busy", bus.busy, 1);
        bus.req = '0;
        step();
        check("one_ack_bit0", bus.ack, 0);
        check("one_vld_bit0", bus.ser_valid, 1);
        check("one_out_v1", out_bit, 1);
        step();
        check("one_vld_end", bus.ser_valid, 0);
        check("one_busy_end", bus.busy, 0);
        check("one_out_v2", out_bit, 0);

        // Idle gap: valid stays low, data holds
        for (int i = 0; i < 5; i++) begin
            step();
            check("gap_vld", bus.ser_valid, 0);
            check("gap_sym", {bus.ser_v1, bus.ser_v2}, 2'b10);
            check("gap_ack", bus.ack, 0);
        end

        // All requesters held after a fresh reset: 0,1,2,3,0
        bus.sym = 8'b11_10_01_00;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 4'b1111;
        seq_a   = '{0, 1, 2, 3, 0, 0, 0, 0};
        run_seq("all", seq_a, 5);

        // Late arrival: 3 alone, then 1 asserts during BIT0 (pointer is 0)
        bus.req = 4'b1000;
        step();
        check("late_ack3", bus.ack, 4'b1000);
        check("late_src3", bus.ser_src, 3);
        bus.req = 4'b0010;
        step();
        check("late_bit0_ack", bus.ack, 0);
        check("late_bit0_src", bus.ser_src, 3);
        step();
        check("late_ack1", bus.ack, 4'b0010);
        check("late_src1", bus.ser_src, 1);
        check("late_vld", bus.ser_valid, 1);
        check("late_sym1", {bus.ser_v1, bus.ser_v2}, 2'b01);
        bus.req = '0;
        step();
        step();
        check("late_end_vld", bus.ser_valid, 0);

        // Reset mid-symbol: grant 2, reset in BIT0, then 0 wins over 2
        bus.req = 4'b0100;
        step();
        check("mid_ack2", bus.ack, 4'b0100);
        reset   = 1'b1;
        bus.req = '0;
        step();
        check("mid_vld", bus.ser_valid, 0);
        check("mid_ack", bus.ack, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_src", bus.ser_src, 0);
        reset   = 1'b0;
        bus.req = 4'b0101;
        step();
        check("mid_regrant", bus.ack, 4'b0001);
        check("mid_regrant_src", bus.ser_src, 0);
        bus.req = '0;
        step();
        step();
        check("mid_end_vld", bus.ser_valid, 0);

        // Two held requesters from reset: burst or strict alternation
        reset = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 4'b0011;
`ifdef SER_ARB_BURST_EN
        seq_a = '{0, 0, 0, 1, 1, 1, 0, 0};
`else
        seq_a = '{0, 1, 0, 1, 0, 1, 0, 0};
`endif
        run_seq("pair", seq_a, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin scheduler that shares one 2-bit-symbol serializer among NUM_REQ requesters. Each requester offers a 2-bit symbol {v1,v2}. The block grants one requester at a time and drives the serializer's valid/v1/v2 inputs for exactly two cycles per symbol, keeping the serializer's internal bit index aligned. It sits directly upstream of the serializer in the transmit path.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_BURST, 4: maximum consecutive symbols per grant when burst mode is compiled in, 1..15.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, sampled on posedge clk.
- req  in  NUM_REQ  requester i has a symbol pending; must be held until acknowledged.
- sym  in  2*NUM_REQ  symbol of requester i at bits [2i+1:2i]; bit 2i+1 = v1 (sent first), bit 2i = v2.
- ack  out  NUM_REQ  registered one-hot, one-cycle pulse: symbol of requester i was taken.
- ser_valid  out  1  to serializer valid.
- ser_v1  out  1  to serializer v1.
- ser_v2  out  1  to serializer v2.
- ser_src  out  $clog2(NUM_REQ)  index of the requester whose symbol is on ser_v1/ser_v2.
- busy  out  1  high in BIT0/BIT1.

## Operation
- Reset: state IDLE. ack=0, ser_valid=0, ser_v1=0, ser_v2=0, ser_src=0, busy=0. RR pointer = NUM_REQ-1, so requester 0 has top priority first. burst_cnt=0.
- States:
  - IDLE: nothing being sent.
  - BIT0: first serializer cycle.
  - BIT1: second serializer cycle.
- IDLE: if any req is set, pick the winner by round-robin and latch sym[winner] into ser_v1/ser_v2. Set ser_src=winner, ack[winner]=1, go to BIT0. Otherwise stay in IDLE.
- BIT0: ser_valid=1. ack pulse is visible this cycle. No arbitration. Go to BIT1.
- BIT1: ser_valid=1 and data unchanged. Arbitrate as in IDLE.
  - If there is a winner, go to BIT0 back-to-back with no idle gap. Throughput is 1 symbol per 2 cycles.
  - Otherwise go to IDLE, and ser_valid drops to 0.
- Round-robin: search starts at pointer+1 with wrap modulo NUM_REQ; the first set req wins. Pointer is set to the winner on each grant.
- Requester rule: after the ack pulse, the requester must drop req or present its next symbol by the next posedge. The arbiter never samples req during BIT0.
- ser_valid is never high for an odd number of consecutive cycles. Each run is exactly 2k cycles, so the serializer's bit index returns to 0 at the end of every run.
- ser_v1, ser_v2 and ser_src hold their values while in IDLE. Only ser_valid is meaningful there.

## Timing
- Grant latency: req first sampled high on edge E (state IDLE or BIT1) → ack, ser_valid, data and ser_src all valid in the cycle after E.
- Serializer output: serializer out_bit carries v1 one cycle after BIT0 and v2 one cycle after BIT1, i.e. 2 and 3 cycles after edge E.
- Simultaneous requests: resolved in a single cycle, in round-robin order.
- A requester whose req falls before it is granted is not served. No error is flagged.
- Reset mid-symbol: state returns to IDLE at the next edge and the partial symbol is dropped. ser_valid=0 in the next cycle; the serializer self-aligns because valid goes low.

## Configuration
- SER_ARB_BURST_EN defined: in BIT1 the current owner keeps the grant if all of the following hold, ignoring the round-robin order:
  - its req is still high;
  - burst_cnt < MAX_BURST-1.
- In burst mode, burst_cnt increments on each kept grant. It clears to 0 on a grant to a different requester or on entry to IDLE. The pointer is updated only when ownership changes.
- SER_ARB_BURST_EN undefined: strict round-robin on every symbol, with no burst_cnt logic. MAX_BURST is ignored.

## Structure
- Package ser_arb_pkg:
  - state enum {IDLE, BIT0, BIT1};
  - SYM_W=2;
  - function for index width.
- Sub-module rr_picker: combinational. Inputs are req vector and pointer; outputs are a found flag and winner index. It is parameterised by NUM_REQ.
- Top level holds the FSM, data/ack registers and the optional burst counter.

## Test plan
- Reset check: reset high for 2 cycles → all outputs 0 and pointer = NUM_REQ-1. Then req=4'b0001 with sym0=2'b10 → ack=0001 in the cycle after req is sampled. ser_valid is high for 2 cycles with ser_v1=1, ser_v2=0, ser_src=0. Serializer out_bit sequence is 1 then 0.
- All requesters held: req=4'b1111 held with sym i = i → grants in order 0,1,2,3,0 with ser_valid continuously high. Each symbol occupies 2 cycles; the first ack appears 1 cycle after req is first sampled, then one ack every 2 cycles.
- Late arrival: requester 3 requests alone and is served; requester 1 asserts req during BIT0 → requester 1 is granted at the end of BIT1, with no idle cycle between the two symbols.
- Reset mid-symbol: reset asserted during BIT0 → next cycle ser_valid=0, state IDLE, no ack. The following grant goes to requester 0.
- Burst mode (SER_ARB_BURST_EN, MAX_BURST=3): req=4'b0011 held → sequence 0,0,0,1,1,1,0. Without the macro the sequence is 0,1,0,1.
- Idle gap: single symbol, then req low for 5 cycles → ser_valid low for those cycles and ser_v1/ser_v2 keep their last values. The next request is accepted normally.
